mem_cycle_sequencer: RTL and testbench

MEM_CYCLE_SEQUENCER -- requirements
Module: mem_cycle_sequencer

---
 rtl/mem_cycle_sequencer_pkg.sv | 33 +++
 rtl/mem_cycle_sequencer_if.sv | 37 +++
 rtl/mem_cycle_sequencer_wait_timer.sv | 39 +++
 rtl/mem_cycle_sequencer.sv | 143 ++++++++++++++
 tb/tb_mem_cycle_sequencer.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/mem_cycle_sequencer_pkg.sv
// Shared definitions for the memory-cycle sequencer: opcodes, FSM states,
// memory address source selects and a small state helper.
package mem_cycle_sequencer_pkg;

  // Instruction classes as seen by the decoder feeding this sequencer.
  typedef enum logic [1:0] {
    OP_ALU   = 2'd0,
    OP_LOAD  = 2'd1,
    OP_STORE = 2'd2,
    OP_END   = 2'd3
  } opcode_e;

  // Sequencer FSM state encoding.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5,
    ST_ERROR  = 3'd6
  } state_e;

  // Memory address source: program counter for fetches, ALU result for data.
  localparam logic ADDR_PC  = 1'b0;
  localparam logic ADDR_ALU = 1'b1;

  // True in the states that own the memory port.
  function automatic logic is_access_state(input state_e st);
    return (st == ST_FETCH) || (st == ST_MEM);
  endfunction

endpackage

// File: rtl/mem_cycle_sequencer_if.sv
// Control/status bundle between the sequencer and the datapath + memory.
// master = sequencer side, slave = datapath/memory/environment side.
interface mem_cycle_sequencer_if #(
  parameter int CNT_W = 32
);
  // Towards the sequencer
  logic             run;
  logic             mem_ready;
  logic             mem_read_ctl;
  logic             mem_write_ctl;
  logic             reg_write_ctl;
  logic             end_program;
  // From the sequencer
  logic             mem_req;
  logic             mem_addr_sel;
  logic             mem_we;
  logic             ir_we;
  logic             mdr_we;
  logic             rf_we;
  logic             pc_we;
  logic             halted;
  logic             bus_error;
  logic [CNT_W-1:0] retired;

  modport master (
    input  run, mem_ready, mem_read_ctl, mem_write_ctl, reg_write_ctl, end_program,
    output mem_req, mem_addr_sel, mem_we, ir_we, mdr_we, rf_we, pc_we,
           halted, bus_error, retired
  );

  modport slave (
    output run, mem_ready, mem_read_ctl, mem_write_ctl, reg_write_ctl, end_program,
    input  mem_req, mem_addr_sel, mem_we, ir_we, mdr_we, rf_we, pc_we,
           halted, bus_error, retired
  );

endinterface

// File: rtl/mem_cycle_sequencer_wait_timer.sv
// Per-access wait counter with timeout comparator. Counts cycles in which the
// memory has not yet answered; expired flags that the budget is used up.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic tick,
  output logic expired
);

  localparam int CW = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Clear wins; saturate at the limit so the counter can never wrap back.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (tick && !expired) begin
      count_d = count_q + CW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == CW'(MEM_TIMEOUT));

endmodule

// File: rtl/mem_cycle_sequencer.sv
// Multi-cycle instruction sequencer for a unified single-port memory:
// FETCH -> DECODE -> (MEM) -> WB, with timeout to ERROR and END to HALT.
// Outputs are decoded from state; only ir_we and mdr_we also look at
// mem_ready so the load strobe lands on the cycle the data is valid.
module mem_cycle_sequencer #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mem_cycle_sequencer_if.master bus
);
  import mem_cycle_sequencer_pkg::*;

  state_e           state_q;
  state_e           state_d;
  logic [CNT_W-1:0] retired_q;
  logic [CNT_W-1:0] retired_d;
  logic             timer_clear;
  logic             timer_tick;
  logic             timer_expired;

  logic mem_req_o;
  logic mem_addr_sel_o;
  logic mem_we_o;
  logic ir_we_o;
  logic mdr_we_o;
  logic rf_we_o;
  logic pc_we_o;
  logic halted_o;
  logic bus_error_o;

  // The counter sits at zero whenever the memory port is not owned, so it
  // always starts fresh on entry to FETCH or MEM.
  assign timer_clear = !is_access_state(state_q);
  assign timer_tick  = is_access_state(state_q) && !bus.mem_ready;

  mem_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_wait_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (timer_clear),
    .tick    (timer_tick),
    .expired (timer_expired)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; mem_ready on the last allowed wait cycle beats timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.run) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (bus.mem_ready)  state_d = ST_DECODE;
        else if (timer_expired) state_d = ST_ERROR;
      end
      ST_DECODE: begin
        if (bus.end_program)                           state_d = ST_HALT;
        else if (bus.mem_read_ctl || bus.mem_write_ctl) state_d = ST_MEM;
        else                                            state_d = ST_WB;
      end
      ST_MEM: begin
        if (bus.mem_ready)  state_d = ST_WB;
        else if (timer_expired) state_d = ST_ERROR;
      end
      ST_WB:    state_d = ST_FETCH;
      ST_HALT:  state_d = ST_HALT;
      ST_ERROR: state_d = ST_ERROR;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output decode; a combined read+write is treated as a store.
  always_comb begin
    mem_req_o      = 1'b0;
    mem_addr_sel_o = ADDR_PC;
    mem_we_o       = 1'b0;
    ir_we_o        = 1'b0;
    mdr_we_o       = 1'b0;
    rf_we_o        = 1'b0;
    pc_we_o        = 1'b0;
    halted_o       = 1'b0;
    bus_error_o    = 1'b0;
    case (state_q)
      ST_FETCH: begin
        mem_req_o = 1'b1;
        ir_we_o   = bus.mem_ready;
      end
      ST_MEM: begin
        mem_req_o      = 1'b1;
        mem_addr_sel_o = ADDR_ALU;
        mem_we_o       = bus.mem_write_ctl;
        mdr_we_o       = bus.mem_ready && bus.mem_read_ctl && !bus.mem_write_ctl;
      end
      ST_WB: begin
        pc_we_o = 1'b1;
        rf_we_o = bus.reg_write_ctl;
      end
      ST_HALT:  halted_o    = 1'b1;
      ST_ERROR: bus_error_o = 1'b1;
      default: begin
      end
    endcase
  end

  // Retired-instruction count advances once per write-back, wrapping.
  always_comb begin
    retired_d = retired_q;
    if (state_q == ST_WB) retired_d = retired_q + CNT_W'(1);
  end

  // Retired counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_q <= '0;
    end else begin
      retired_q <= retired_d;
    end
  end

  assign bus.mem_req      = mem_req_o;
  assign bus.mem_addr_sel = mem_addr_sel_o;
  assign bus.mem_we       = mem_we_o;
  assign bus.ir_we        = ir_we_o;
  assign bus.mdr_we       = mdr_we_o;
  assign bus.rf_we        = rf_we_o;
  assign bus.pc_we        = pc_we_o;
  assign bus.halted       = halted_o;
  assign bus.bus_error    = bus_error_o;
  assign bus.retired      = retired_q;

endmodule

// File: tb/tb_mem_cycle_sequencer.sv
// Randomized bench: each episode is planned at instruction level (controls
// plus per-access memory wait counts), turned into an expected per-cycle
// timeline by plain arithmetic, then replayed against the DUT. Each episode
// ends with an asynchronous reset, usually in the middle of a data access.
module tb_mem_cycle_sequencer;

  localparam int TO   = 15;
  localparam int CW   = 4;
  localparam int MAXC = 2048;
  localparam int N_EP = 30;

  // Bit positions of the packed output vector.
  localparam logic [8:0] O_REQ  = 9'h100;
  localparam logic [8:0] O_SEL  = 9'h080;
  localparam logic [8:0] O_WE   = 9'h040;
  localparam logic [8:0] O_IR   = 9'h020;
  localparam logic [8:0] O_MDR  = 9'h010;
  localparam logic [8:0] O_RF   = 9'h008;
  localparam logic [8:0] O_PC   = 9'h004;
  localparam logic [8:0] O_HALT = 9'h002;
  localparam logic [8:0] O_ERR  = 9'h001;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  mem_cycle_sequencer_if #(.CNT_W(CW)) bus_if ();

  mem_cycle_sequencer #(
    .MEM_TIMEOUT (TO),
    .CNT_W       (CW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.master)
  );

  always #5 clk = ~clk;

  int n_compared   = 0;
  int n_mismatched = 0;

  // Per-cycle stimulus and expectations for the current episode.
  bit         stim_run [MAXC];
  bit         stim_rdy [MAXC];
  bit [3:0]   stim_ctl [MAXC];   // {rd, wr, rw, end}
  logic [8:0] exp_outs [MAXC];
  int         exp_ret  [MAXC];
  int         n_cyc;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] obs_outs();
    return {bus_if.mem_req, bus_if.mem_addr_sel, bus_if.mem_we, bus_if.ir_we,
            bus_if.mdr_we, bus_if.rf_we, bus_if.pc_we, bus_if.halted, bus_if.bus_error};
  endfunction

  function automatic bit rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Memory latency for one access; values above TO mean "never answers".
  function automatic int pick_wait();
    int r;
    r = $urandom_range(0, 99);
    if (r < 55) return 0;
    if (r < 80) return $urandom_range(1, 3);
    if (r < 88) return TO;
    if (r < 92) return TO - 1;
    return TO + 1;
  endfunction

  task automatic push(input bit run, input bit rdy, input bit [3:0] ctl,
                      input logic [8:0] outs, input int ret);
    if (n_cyc < MAXC) begin
      stim_run[n_cyc] = run;
      stim_rdy[n_cyc] = rdy;
      stim_ctl[n_cyc] = ctl;
      exp_outs[n_cyc] = outs;
      exp_ret[n_cyc]  = ret;
      n_cyc++;
    end
  endtask

  task automatic build_episode(input bit directed);
    int       n_idle, n_instr, ret, wf, wm, n_tail;
    bit       done;
    logic [8:0] term;
    bit       rd, wr, rw, en;
    bit [3:0] ctl;
    n_cyc = 0;
    ret   = 0;
    done  = 1'b0;
    term  = 9'h0;
    n_idle = directed ? 0 : $urandom_range(1, 3);
    for (int i = 0; i < n_idle; i++) push(1'b0, rbit(), 4'($urandom_range(0, 15)), 9'h0, 0);
    push(1'b1, rbit(), 4'($urandom_range(0, 15)), 9'h0, 0);
    n_instr = directed ? 3 : $urandom_range(2, 20);
    for (int k = 0; k < n_instr && !done; k++) begin
      rd  = directed ? 1'b0 : rbit();
      wr  = directed ? 1'b0 : rbit();
      rw  = directed ? 1'b1 : rbit();
      en  = directed ? 1'b0 : ($urandom_range(0, 15) == 0);
      ctl = {rd, wr, rw, en};
      wf  = directed ? 0 : pick_wait();
      wm  = directed ? 0 : pick_wait();
      // instruction fetch
      if (wf > TO) begin
        for (int c = 0; c <= TO; c++) push(rbit(), 1'b0, ctl, O_REQ, ret);
        done = 1'b1;
        term = O_ERR;
      end else begin
        for (int c = 0; c <= wf; c++)
          push(rbit(), (c == wf), ctl, O_REQ | ((c == wf) ? O_IR : 9'h0), ret);
      end
      if (!done) begin
        push(rbit(), rbit(), ctl, 9'h0, ret);   // decode
        if (en) begin
          done = 1'b1;
          term = O_HALT;
        end else begin
          if (rd || wr) begin
            if (wm > TO) begin
              for (int c = 0; c <= TO; c++)
                push(rbit(), 1'b0, ctl, O_REQ | O_SEL | (wr ? O_WE : 9'h0), ret);
              done = 1'b1;
              term = O_ERR;
            end else begin
              for (int c = 0; c <= wm; c++)
                push(rbit(), (c == wm), ctl,
                     O_REQ | O_SEL | (wr ? O_WE : 9'h0) |
                     ((c == wm && rd && !wr) ? O_MDR : 9'h0), ret);
            end
          end
          if (!done) begin
            push(rbit(), rbit(), ctl, O_PC | (rw ? O_RF : 9'h0), ret);  // write-back
            ret = (ret + 1) % (1 << CW);
          end
        end
      end
    end
    if (done) begin
      for (int i = 0; i < 20; i++) push(rbit(), rbit(), 4'($urandom_range(0, 15)), term, ret);
    end else begin
      // Start a load/store and leave it hanging so reset lands inside MEM.
      wr  = rbit();
      ctl = {1'b1, wr, rbit(), 1'b0};
      push(rbit(), 1'b1, ctl, O_REQ | O_IR, ret);
      push(rbit(), rbit(), ctl, 9'h0, ret);
      n_tail = $urandom_range(1, 3);
      for (int c = 0; c < n_tail; c++)
        push(rbit(), 1'b0, ctl, O_REQ | O_SEL | (wr ? O_WE : 9'h0), ret);
    end
  endtask

  task automatic run_episode(input int ep);
    logic [8:0] outs;
    for (int t = 0; t < n_cyc; t++) begin
      @(negedge clk);
      if (t == 0) rst_n = 1'b1;
      bus_if.run           = stim_run[t];
      bus_if.mem_ready     = stim_rdy[t];
      bus_if.mem_read_ctl  = stim_ctl[t][3];
      bus_if.mem_write_ctl = stim_ctl[t][2];
      bus_if.reg_write_ctl = stim_ctl[t][1];
      bus_if.end_program   = stim_ctl[t][0];
      #1;
      outs = obs_outs();
      check_val($sformatf("ep%0d.c%0d.outs", ep, t), 64'(outs), 64'(exp_outs[t]));
      check_val($sformatf("ep%0d.c%0d.retired", ep, t), 64'(bus_if.retired), 64'(exp_ret[t]));
    end
    // Asynchronous reset between clock edges, with memory claiming ready.
    #1;
    bus_if.mem_ready     = 1'b1;
    bus_if.mem_read_ctl  = 1'b1;
    bus_if.mem_write_ctl = 1'b1;
    bus_if.reg_write_ctl = 1'b1;
    rst_n = 1'b0;
    #1;
    outs = obs_outs();
    check_val($sformatf("ep%0d.reset.outs", ep), 64'(outs), 64'(9'h0));
    check_val($sformatf("ep%0d.reset.retired", ep), 64'(bus_if.retired), 64'(0));
    @(negedge clk);
    $display("episode %0d: %0d cycles, final retired %0d", ep, n_cyc, exp_ret[n_cyc-1]);
  endtask

  initial begin
    bus_if.run           = 1'b0;
    bus_if.mem_ready     = 1'b0;
    bus_if.mem_read_ctl  = 1'b0;
    bus_if.mem_write_ctl = 1'b0;
    bus_if.reg_write_ctl = 1'b0;
    bus_if.end_program   = 1'b0;
    #2;
    check_val("initial_reset.outs", 64'(obs_outs()), 64'(9'h0));
    check_val("initial_reset.retired", 64'(bus_if.retired), 64'(0));
    for (int ep = 0; ep < N_EP; ep++) begin
      build_episode(ep == 0);
      run_episode(ep);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
